// File: rtl/burst_framer_pkg.sv
// Shared definitions for burst_framer: FSM state codes, header field layout
// and the header word builder.
package burst_framer_pkg;

    localparam int unsigned STATE_W = 2;

    localparam logic [STATE_W-1:0] S_IDLE = 2'd0;
    localparam logic [STATE_W-1:0] S_HDR  = 2'd1;
    localparam logic [STATE_W-1:0] S_DATA = 2'd2;

    // Header layout: {zero pad, len[LEN_BITS-1:0] at LEN_LSB, addr[LEN_LSB-1:0]}
    localparam int unsigned LEN_BITS  = 16;
    localparam int unsigned HDR_MAX_W = 256;

    // addr must arrive zero-extended; lenLsb is the address width of the instance.
    function automatic logic [HDR_MAX_W-1:0] make_header(
        input logic [LEN_BITS-1:0]  len,
        input logic [HDR_MAX_W-1:0] addr,
        input int unsigned          lenLsb
    );
        logic [HDR_MAX_W-1:0] hdr;
        hdr = addr | (HDR_MAX_W'(len) << lenLsb);
        return hdr;
    endfunction

endpackage

// File: rtl/burst_framer.sv
// Drains full chunks from the buffer FIFO as SOP/EOP-framed bursts (header + data).
// Optional short-burst flush on idle timeout when BURST_FRAMER_FLUSH_EN is defined.
module burst_framer
    import burst_framer_pkg::*;
#(
    parameter int unsigned WIDTH      = 64,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned CHUNKSIZE  = 4,
    parameter int unsigned ADDR_WIDTH = 32
`ifdef BURST_FRAMER_FLUSH_EN
    ,
    parameter int unsigned FLUSH_TIMEOUT = 256
`endif
) (
    input  logic                  clk_in,
    input  logic                  reset_in,
    input  logic [DEPTH-1:0]      fDepth_in,
    input  logic [WIDTH-1:0]      fData_in,
    input  logic                  fValid_in,
    input  logic                  fValidChunk_in,
    output logic                  fReady_out,
    input  logic [ADDR_WIDTH-1:0] cfgBase_in,
    input  logic                  cfgLoad_in,
    output logic [WIDTH-1:0]      oData_out,
    output logic                  oValid_out,
    output logic                  oSop_out,
    output logic                  oEop_out,
    input  logic                  oReady_in,
    output logic [15:0]           burstCount_out
);

    localparam int unsigned LEN_LSB = ADDR_WIDTH;

    logic [STATE_W-1:0]    stateQ;
    logic [STATE_W-1:0]    stateD;
    logic [LEN_BITS-1:0]   lenQ;
    logic [LEN_BITS-1:0]   newLen;
    logic [LEN_BITS-1:0]   beatQ;
    logic [ADDR_WIDTH-1:0] addrQ;
    logic [ADDR_WIDTH-1:0] hdrAddrQ;
    logic [15:0]           burstCountQ;
    logic                  latchBurst;
    logic                  hdrAccept;
    logic                  beatXfer;
    logic                  eopXfer;
    logic                  lastBeat;
    logic                  flushDue;

    assign lastBeat       = (beatQ == lenQ - LEN_BITS'(1));
    assign burstCount_out = burstCountQ;

`ifdef BURST_FRAMER_FLUSH_EN
    localparam int unsigned TIMER_W = $clog2(FLUSH_TIMEOUT + 1);

    logic [TIMER_W-1:0] flushTimerQ;
    logic               partialIdle;

    // Counts idle cycles spent holding less than a chunk; expiry forces a short burst.
    assign partialIdle = (stateQ == S_IDLE) && fValid_in && !fValidChunk_in;
    assign flushDue    = partialIdle && (flushTimerQ == TIMER_W'(FLUSH_TIMEOUT - 1));

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            flushTimerQ <= '0;
        end else if (partialIdle && !flushDue) begin
            flushTimerQ <= flushTimerQ + TIMER_W'(1);
        end else begin
            flushTimerQ <= '0;
        end
    end
`else
    logic unusedDepth;

    assign flushDue    = 1'b0;
    assign unusedDepth = ^fDepth_in;
`endif

    // State register
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            stateQ <= S_IDLE;
        end else begin
            stateQ <= stateD;
        end
    end

    // Next state, datapath strobes and stream outputs; DATA is a zero-latency pass-through.
    always_comb begin
        stateD     = stateQ;
        newLen     = LEN_BITS'(CHUNKSIZE);
        latchBurst = 1'b0;
        hdrAccept  = 1'b0;
        beatXfer   = 1'b0;
        eopXfer    = 1'b0;
        fReady_out = 1'b0;
        oValid_out = 1'b0;
        oSop_out   = 1'b0;
        oEop_out   = 1'b0;
        oData_out  = '0;

        case (stateQ)
            S_IDLE: begin
                if (fValidChunk_in) begin
                    latchBurst = 1'b1;
                    stateD     = S_HDR;
                end else if (flushDue) begin
                    latchBurst = 1'b1;
                    newLen     = LEN_BITS'(fDepth_in);
                    stateD     = S_HDR;
                end
            end

            S_HDR: begin
                oValid_out = 1'b1;
                oSop_out   = 1'b1;
                oData_out  = WIDTH'(make_header(lenQ, HDR_MAX_W'(hdrAddrQ), LEN_LSB));
                if (oReady_in) begin
                    hdrAccept = 1'b1;
                    stateD    = S_DATA;
                end
            end

            S_DATA: begin
                fReady_out = oReady_in;
                oValid_out = fValid_in;
                oData_out  = fData_in;
                oEop_out   = lastBeat;
                if (fValid_in && oReady_in) begin
                    beatXfer = 1'b1;
                    if (lastBeat) begin
                        eopXfer = 1'b1;
                        stateD  = S_IDLE;
                    end
                end
            end

            default: begin
                stateD = S_IDLE;
            end
        endcase
    end

    // Burst length/address latch, beat counter, running address and burst counter.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            lenQ        <= '0;
            hdrAddrQ    <= '0;
            beatQ       <= '0;
            addrQ       <= '0;
            burstCountQ <= '0;
        end else begin
            if (latchBurst) begin
                lenQ     <= newLen;
                hdrAddrQ <= addrQ;
            end

            if (hdrAccept) begin
                beatQ <= '0;
            end else if (beatXfer) begin
                beatQ <= beatQ + LEN_BITS'(1);
            end

            if (eopXfer) begin
                burstCountQ <= burstCountQ + 16'd1;
            end

            // A configuration load takes priority over the end-of-burst advance.
            if (cfgLoad_in) begin
                addrQ <= cfgBase_in;
            end else if (eopXfer) begin
                addrQ <= addrQ + ADDR_WIDTH'(lenQ);
            end
        end
    end

endmodule

// File: tb/tb_burst_framer.sv
// Self-checking bench for burst_framer behind a behavioural show-ahead FIFO,
// scored against a stream-level model of the expected framed output.
module tb_burst_framer;

    localparam int unsigned WIDTH      = 64;
    localparam int unsigned DEPTH      = 4;
    localparam int unsigned CHUNKSIZE  = 4;
    localparam int unsigned ADDR_WIDTH = 32;

    logic                  clk_in = 1'b0;
    logic                  reset_in = 1'b1;
    logic [DEPTH-1:0]      fDepth_in = '0;
    logic [WIDTH-1:0]      fData_in = '0;
    logic                  fValid_in = 1'b0;
    logic                  fValidChunk_in = 1'b0;
    logic                  fReady_out;
    logic [ADDR_WIDTH-1:0] cfgBase_in = '0;
    logic                  cfgLoad_in = 1'b0;
    logic [WIDTH-1:0]      oData_out;
    logic                  oValid_out;
    logic                  oSop_out;
    logic                  oEop_out;
    logic                  oReady_in = 1'b0;
    logic [15:0]           burstCount_out;

    burst_framer #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .CHUNKSIZE(CHUNKSIZE),
        .ADDR_WIDTH(ADDR_WIDTH)
`ifdef BURST_FRAMER_FLUSH_EN
        ,
        .FLUSH_TIMEOUT(16)
`endif
    ) dut (
        .clk_in(clk_in),
        .reset_in(reset_in),
        .fDepth_in(fDepth_in),
        .fData_in(fData_in),
        .fValid_in(fValid_in),
        .fValidChunk_in(fValidChunk_in),
        .fReady_out(fReady_out),
        .cfgBase_in(cfgBase_in),
        .cfgLoad_in(cfgLoad_in),
        .oData_out(oData_out),
        .oValid_out(oValid_out),
        .oSop_out(oSop_out),
        .oEop_out(oEop_out),
        .oReady_in(oReady_in),
        .burstCount_out(burstCount_out)
    );

    always #5 clk_in = ~clk_in;

    int nChecks = 0;
    int nFails  = 0;

    // Stimulus controls
    logic        rstReq = 1'b1;
    logic        pushReq = 1'b0;
    logic [63:0] pushVal = '0;
    logic        loadReq = 1'b0;
    logic [31:0] loadVal = '0;
    logic        loadOnEop = 1'b0;
    logic [31:0] eopBase = '0;
    int          rdyMode = 0;
    logic [3:0]  bpPat = 4'b1001;

    // FIFO model and stream-level reference
    logic [63:0] fifoQ[$];
    int          mLen = CHUNKSIZE;
    logic [31:0] mAddr = '0;
    logic [15:0] mCount = '0;
    bit          inData = 1'b0;
    int          beat = 0;
    bit          hdrWait = 1'b0;
    logic [63:0] hdrWaitData = '0;
    logic [63:0] lastHdr = '0;
    int          burstsDone = 0;

    int cyc = 0;
    int pushCyc = 0;
    int hdrStartCyc = 0;
    int validSeen = 0;
    int idleWithData = 0;

    task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Scores one non-reset cycle against the expected framed stream.
    task automatic score();
        checkEq("burstCount", 64'(burstCount_out), 64'(mCount));
        if (oValid_out) validSeen++;
        if (!inData) begin
            checkEq("fReadyOutsideData", 64'(fReady_out), 64'(0));
            if (fValid_in && !oValid_out) idleWithData++;
            if (hdrWait) begin
                checkEq("hdrHeldValid", 64'(oValid_out), 64'(1));
                checkEq("hdrHeldData", oData_out, hdrWaitData);
            end else if (oValid_out) begin
                hdrStartCyc = cyc;
            end
            hdrWait = 1'b0;
            if (oValid_out) begin
                checkEq("hdrSop", 64'(oSop_out), 64'(1));
                checkEq("hdrEop", 64'(oEop_out), 64'(0));
                checkEq("hdrWord", oData_out, {16'h0, 16'(mLen), mAddr});
                if (oReady_in) begin
                    inData  = 1'b1;
                    beat    = 0;
                    lastHdr = oData_out;
                end else begin
                    hdrWait     = 1'b1;
                    hdrWaitData = oData_out;
                end
            end
        end else begin
            checkEq("fReadyFollowsReady", 64'(fReady_out), 64'(oReady_in));
            checkEq("dataValid", 64'(oValid_out), 64'(fValid_in));
            checkEq("dataSop", 64'(oSop_out), 64'(0));
            if (oValid_out && fifoQ.size() != 0) begin
                checkEq("dataWord", oData_out, fifoQ[0]);
                checkEq("dataEop", 64'(oEop_out), 64'(beat == mLen - 1));
            end
            if (fValid_in && oReady_in) begin
                if (beat == mLen - 1) begin
                    inData = 1'b0;
                    mCount++;
                    burstsDone++;
                    mAddr = mAddr + 32'(mLen);
                    if (loadOnEop) begin
                        cfgLoad_in = 1'b1;
                        cfgBase_in = eopBase;
                        mAddr      = eopBase;
                        loadOnEop  = 1'b0;
                    end
                end else begin
                    beat++;
                end
            end
        end
        if (loadReq) mAddr = loadVal;
    endtask

    // One clock: drive at negedge, sample 1 time unit later, then advance the FIFO model.
    task automatic cycle();
        logic pop;
        @(negedge clk_in);
        reset_in       = rstReq;
        cfgLoad_in     = loadReq;
        cfgBase_in     = loadVal;
        case (rdyMode)
            0:       oReady_in = 1'b1;
            1:       oReady_in = bpPat[cyc % 4];
            default: oReady_in = 1'($urandom % 2);
        endcase
        fValid_in      = (fifoQ.size() != 0);
        fData_in       = fValid_in ? fifoQ[0] : 64'hDEAD_BEEF_0BAD_F00D;
        fDepth_in      = 4'(fifoQ.size());
        fValidChunk_in = (fifoQ.size() >= CHUNKSIZE);
        #1;
        cyc++;
        if (!rstReq) score();
        pop = fValid_in && fReady_out;
        if (rstReq) begin
            fifoQ.delete();
            mAddr   = '0;
            mCount  = '0;
            inData  = 1'b0;
            hdrWait = 1'b0;
            beat    = 0;
        end else begin
            if (pop) void'(fifoQ.pop_front());
            if (pushReq) fifoQ.push_back(pushVal);
        end
        pushReq = 1'b0;
        loadReq = 1'b0;
    endtask

    task automatic waitBursts(input int n, input int limit);
        int goal;
        int k;
        goal = burstsDone + n;
        k    = 0;
        while (burstsDone < goal && k < limit) begin
            cycle();
            k++;
        end
        checkEq("burstsWithinBudget", 64'(burstsDone), 64'(goal));
    endtask

    task automatic pushChunk(input logic [63:0] base);
        for (int i = 0; i < int'(CHUNKSIZE); i++) begin
            pushReq = 1'b1;
            pushVal = base + 64'(i);
            cycle();
        end
        pushCyc = cyc;
    endtask

    initial begin
        int k;
        int start;
        int pushed;

        // Reset
        rstReq = 1'b1;
        cycle();
        cycle();
        rstReq = 1'b0;
        cycle();
        checkEq("rstValid", 64'(oValid_out), 64'(0));
        checkEq("rstSop", 64'(oSop_out), 64'(0));
        checkEq("rstEop", 64'(oEop_out), 64'(0));
        checkEq("rstFReady", 64'(fReady_out), 64'(0));
        checkEq("rstCount", 64'(burstCount_out), 64'(0));

        // Single burst A0..A3
        rdyMode = 0;
        pushChunk(64'hA0);
        waitBursts(1, 50);
        checkEq("t1Latency", 64'(hdrStartCyc - pushCyc), 64'(2));
        checkEq("t1Hdr", lastHdr, 64'h0000_0004_0000_0000);
        cycle();
        checkEq("t1Count", 64'(burstCount_out), 64'(1));

        // Backpressure 1,0,0,1
        rdyMode = 1;
        pushChunk(64'hB0);
        waitBursts(1, 100);
        checkEq("t2Hdr", lastHdr, 64'h0000_0004_0000_0004);

        // Randomized traffic and readiness
        rdyMode = 2;
        start   = burstsDone;
        pushed  = 0;
        k       = 0;
        while (burstsDone - start < 12 && k < 3000) begin
            if (pushed < 48 && fifoQ.size() < 15 && ($urandom % 4) != 0) begin
                pushReq = 1'b1;
                pushVal = {$urandom, $urandom};
                pushed++;
            end
            cycle();
            k++;
        end
        checkEq("randomBursts", 64'(burstsDone - start), 64'(12));

        // Address load, wrap, and load coinciding with EOP
        rdyMode = 0;
        cycle();
        loadReq = 1'b1;
        loadVal = 32'hFFFF_FFFE;
        cycle();
        pushChunk(64'hC0);
        waitBursts(1, 50);
        checkEq("wrapHdr0", 64'(lastHdr[31:0]), 64'hFFFF_FFFE);
        loadOnEop = 1'b1;
        eopBase   = 32'h100;
        pushChunk(64'hD0);
        waitBursts(1, 50);
        checkEq("wrapHdr1", 64'(lastHdr[31:0]), 64'h2);
        pushChunk(64'hE0);
        waitBursts(1, 50);
        checkEq("loadOnEopHdr", 64'(lastHdr[31:0]), 64'h100);

`ifdef BURST_FRAMER_FLUSH_EN
        // Short burst after idle timeout
        mLen         = 2;
        idleWithData = 0;
        for (int i = 0; i < 2; i++) begin
            pushReq = 1'b1;
            pushVal = 64'hF0 + 64'(i);
            cycle();
        end
        waitBursts(1, 100);
        checkEq("flushWait", 64'(idleWithData), 64'(16));
        checkEq("flushLen", 64'(lastHdr[47:32]), 64'h2);
        mLen = CHUNKSIZE;
`else
        // Partial chunk waits indefinitely
        for (int i = 0; i < 3; i++) begin
            pushReq = 1'b1;
            pushVal = 64'hF0 + 64'(i);
            cycle();
        end
        validSeen = 0;
        repeat (1000) cycle();
        checkEq("belowChunkQuiet", 64'(validSeen), 64'(0));
        pushReq = 1'b1;
        pushVal = 64'hF3;
        cycle();
        pushCyc = cyc;
        waitBursts(1, 50);
        checkEq("belowChunkLatency", 64'(hdrStartCyc - pushCyc), 64'(2));
`endif

        // Reset after two data beats
        pushChunk(64'h70);
        k = 0;
        while (!(inData && beat == 2) && k < 50) begin
            cycle();
            k++;
        end
        checkEq("reachBeat2", 64'(inData && beat == 2), 64'(1));
        rstReq = 1'b1;
        cycle();
        rstReq = 1'b0;
        cycle();
        checkEq("midRstValid", 64'(oValid_out), 64'(0));
        checkEq("midRstSop", 64'(oSop_out), 64'(0));
        checkEq("midRstEop", 64'(oEop_out), 64'(0));
        checkEq("midRstFReady", 64'(fReady_out), 64'(0));
        checkEq("midRstCount", 64'(burstCount_out), 64'(0));
        pushChunk(64'h80);
        waitBursts(1, 50);
        checkEq("postRstHdr", lastHdr, 64'h0000_0004_0000_0000);

        repeat (3) cycle();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
